pulse_period_meter: RTL and testbench

// - Measures the period of a pulse train, in clk cycles, between consecutive rising edges of pulse_in.
// - It is the receiving end of the counter/pulse generators: it turns a pulse stream back into a count.
// - It sits between a pulse source (pin or on-chip counter) and display/BCD logic.
// - Supports one-shot and continuous measurement, with saturation/overflow reporting.
//

---
 rtl/pulse_period_meter.sv | 130 +++++++++++++
 tb/tb_pulse_period_meter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Pulse period meter: counts clk cycles between consecutive rising edges of pulse_in.
// Optional 2-flop input synchroniser enabled by defining PULSE_METER_SYNC_EN.
module pulse_period_meter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    output logic             busy,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             overflow
);
    // state     | meaning
    // S_IDLE    | waiting for start
    // S_ARM     | waiting for the first rising edge of a measurement
    // S_MEASURE | counting cycles since the last rising edge
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;
    logic             prev_q, prev_d;
    logic             p;
    logic             rise;

`ifdef PULSE_METER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pulse_in;
            sync2_q <= sync1_q;
        end
    end

    assign p = sync2_q;
`else
    assign p = pulse_in;
`endif

    assign prev_d = p;
    assign rise   = p & ~prev_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) state_d = S_ARM;
            end
            S_ARM: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (rise) begin
                    count_d = CNT_ONE;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (stop) begin
                    // abort wins over a coincident edge: no result is published
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (rise) begin
                    period_d   = count_q;
                    overflow_d = 1'b0;
                    valid_d    = 1'b1;
                    count_d    = CNT_ONE;
                    if (!continuous) state_d = S_IDLE;
                end else if (count_q == CNT_MAX) begin
                    // saturate and re-arm so the next edge restarts timing cleanly
                    period_d   = CNT_MAX;
                    overflow_d = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = S_ARM;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            period_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            prev_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            prev_q     <= prev_d;
        end
    end

    assign busy     = (state_q == S_ARM) || (state_q == S_MEASURE);
    assign period   = period_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: a 16-bit and a 4-bit instance share stimulus
// and are compared every cycle against an edge-timestamp reference model.
module tb_pulse_period_meter;

`ifdef PULSE_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pulse_in = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;

    logic        busy_w, valid_w, ovf_w;
    logic [15:0] period_w;
    logic        busy_n, valid_n, ovf_n;
    logic [3:0]  period_n;

    pulse_period_meter #(.WIDTH(16)) dut_w (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .start(start), .stop(stop),
        .continuous(continuous), .busy(busy_w), .period(period_w), .valid(valid_w),
        .overflow(ovf_w)
    );

    pulse_period_meter #(.WIDTH(4)) dut_n (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .start(start), .stop(stop),
        .continuous(continuous), .busy(busy_n), .period(period_n), .valid(valid_n),
        .overflow(ovf_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: timestamps of rising edges, plain arithmetic on edge index.
    int    cyc = 0;
    int    m_mode[2];      // 0 idle, 1 waiting for first edge, 2 timing
    int    m_t0[2];
    int    m_period[2];
    int    m_ovf[2];
    int    m_valid[2];
    int    m_max[2] = '{65535, 15};
    bit    p_hist[$];      // p as seen by the edge detector, oldest first
    bit    m_prev = 1'b0;

    int    obs_w[$], obs_n[$], obs_ovf_n[$];
    int    last_valid_cyc_w = -1;

    task automatic model_edge();
        bit p_now, rise;
        cyc++;
        p_now = (LAT == 0) ? pulse_in : p_hist[0];
        rise  = p_now && !m_prev;
        if (rst) begin
            m_prev = 1'b0;
            p_hist = '{};
            for (int k = 0; k < LAT; k++) p_hist.push_back(1'b0);
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_period[i] = 0; m_ovf[i] = 0; m_valid[i] = 0;
            end
            return;
        end
        m_prev = p_now;
        if (LAT > 0) begin
            void'(p_hist.pop_front());
            p_hist.push_back(pulse_in);
        end
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0;
            case (m_mode[i])
                0: if (start && !stop) m_mode[i] = 1;
                1: if (stop) m_mode[i] = 0;
                   else if (rise) begin m_mode[i] = 2; m_t0[i] = cyc; end
                default: begin
                    if (stop) m_mode[i] = 0;
                    else if (rise) begin
                        m_period[i] = cyc - m_t0[i];
                        m_ovf[i] = 0; m_valid[i] = 1; m_t0[i] = cyc;
                        if (!continuous) m_mode[i] = 0;
                    end else if (cyc - m_t0[i] == m_max[i]) begin
                        m_period[i] = m_max[i]; m_ovf[i] = 1; m_valid[i] = 1; m_mode[i] = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("busy_w",   32'(busy_w),   32'(m_mode[0] != 0));
        check_val("valid_w",  32'(valid_w),  m_valid[0]);
        check_val("period_w", 32'(period_w), m_period[0]);
        check_val("ovf_w",    32'(ovf_w),    m_ovf[0]);
        check_val("busy_n",   32'(busy_n),   32'(m_mode[1] != 0));
        check_val("valid_n",  32'(valid_n),  m_valid[1]);
        check_val("period_n", 32'(period_n), m_period[1]);
        check_val("ovf_n",    32'(ovf_n),    m_ovf[1]);
        if (valid_w) begin obs_w.push_back(int'(period_w)); last_valid_cyc_w = cyc; end
        if (valid_n) begin obs_n.push_back(int'(period_n)); obs_ovf_n.push_back(int'(ovf_n)); end
    endtask

    task automatic pulses(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            pulse_in = 1'b1;
            for (int j = 0; j < h; j++) step();
            pulse_in = 1'b0;
            for (int j = 0; j < l; j++) step();
        end
    endtask

    task automatic idle(input int n);
        pulse_in = 1'b0;
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        int e0;
        int held;

        for (int k = 0; k < LAT; k++) p_hist.push_back(1'b0);

        // reset held 3 cycles with pulse_in toggling
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pulse_in = k[0];
            step();
            check_val("rst_busy", 32'(busy_w), 0);
            check_val("rst_period", 32'(period_w), 0);
        end
        rst = 1'b0;
        idle(4);

        // one-shot, period 10
        continuous = 1'b0;
        obs_w = '{};
        do_start();
        pulses(5, 5, 3);
        idle(12);
        check_val("oneshot_count", obs_w.size(), 1);
        check_val("oneshot_period", (obs_w.size() > 0) ? obs_w[0] : -1, 10);
        check_val("oneshot_ovf", 32'(ovf_w), 0);
        check_val("oneshot_busy", 32'(busy_w), 0);

        // continuous, periods 7, 12, 2
        continuous = 1'b1;
        obs_w = '{};
        do_start();
        idle(2);
        pulses(1, 6, 1); pulses(1, 11, 1); pulses(1, 1, 1); pulses(1, 3, 1);
        stop = 1'b1; step(); stop = 1'b0;
        idle(4);
        check_val("cont_count", obs_w.size(), 3);
        check_val("cont_p0", (obs_w.size() > 0) ? obs_w[0] : -1, 7);
        check_val("cont_p1", (obs_w.size() > 1) ? obs_w[1] : -1, 12);
        check_val("cont_p2", (obs_w.size() > 2) ? obs_w[2] : -1, 2);

        // saturation on the 4-bit instance, then a 5-cycle pair
        continuous = 1'b0;
        obs_n = '{}; obs_ovf_n = '{};
        do_start();
        idle(2);
        pulses(1, 20, 1);
        check_val("sat_busy_n", 32'(busy_n), 1);
        pulses(1, 4, 2);
        idle(6);
        check_val("sat_count", obs_n.size(), 2);
        check_val("sat_p0", (obs_n.size() > 0) ? obs_n[0] : -1, 15);
        check_val("sat_o0", (obs_ovf_n.size() > 0) ? obs_ovf_n[0] : -1, 1);
        check_val("sat_p1", (obs_n.size() > 1) ? obs_n[1] : -1, 5);
        check_val("sat_o1", (obs_ovf_n.size() > 1) ? obs_ovf_n[1] : -1, 0);

        // stop coincident with a rise during MEASURE
        continuous = 1'b1;
        obs_w = '{};
        do_start();
        idle(2);
        pulses(1, 4, 2);
        idle(LAT + 1);
        held = int'(period_w);
        check_val("abort_pre", held, 5);
        pulse_in = 1'b1;
        if (LAT == 0) stop = 1'b1;
        step();
        pulse_in = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            if (k == LAT - 1) stop = 1'b1;
            step();
        end
        stop = 1'b0;
        check_val("abort_busy", 32'(busy_w), 0);
        check_val("abort_valid", 32'(valid_w), 0);
        check_val("abort_period", 32'(period_w), held);
        idle(3);
        check_val("abort_count", obs_w.size(), 1);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check_val("ss_busy0", 32'(busy_w), 0);
        step();
        check_val("ss_busy1", 32'(busy_w), 0);

        // latency of the valid strobe for period 9
        continuous = 1'b0;
        do_start();
        idle(2);
        pulse_in = 1'b1; step(); e0 = cyc;
        idle(8);
        pulse_in = 1'b1; step();
        idle(8);
        check_val("lat_period", 32'(period_w), 9);
        check_val("lat_cycles", last_valid_cyc_w - e0, 9 + LAT);

        // reset mid-measurement
        continuous = 1'b1;
        do_start();
        pulses(2, 3, 3);
        rst = 1'b1; step(); rst = 1'b0;
        check_val("midrst_period", 32'(period_w), 0);
        check_val("midrst_busy", 32'(busy_w), 0);
        idle(3);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) pulse_in = ~pulse_in;
            if ($urandom_range(0, 40) == 0) pulse_in = 1'b0;
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 30) == 0) continuous = ~continuous;
            rst        = ($urandom_range(0, 400) == 0);
            if ($urandom_range(0, 150) == 0) begin
                pulse_in = 1'b0; start = 1'b0; stop = 1'b0; rst = 1'b0;
                for (int j = 0; j < 20; j++) step();
            end else begin
                step();
            end
        end
        start = 1'b0; stop = 1'b0; rst = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
